// File: rtl/dist_calc_seq.sv
// dist_calc_seq: sequential |tr(A^H B)|^2 for DIM x DIM complex fixed-point matrices.
// One element pair is requested per cycle (idx_row/idx_col qualified by rd_en);
// the memories answer one cycle later on a_*/b_*. Products conj(a)*b are
// accumulated, then the squared magnitude of the sum is written to dist2
// together with a one-cycle done pulse.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             start request (only honoured when idle)
//   busy              calculation in progress
//   rd_en             element request strobe
//   idx_row, idx_col  requested element (row-major walk)
//   a_re/a_im/b_re/b_im  signed element data, valid the cycle after a request
//   dist2             unsigned result, 2*FRAC_BITS fractional bits
//   done              one-cycle pulse when dist2 updates
//   max_dist2, new_max  largest result since reset / new-maximum pulse
//                       (present only when DIST_MAX_TRACK_EN is defined)
//
// Optional feature macro: DIST_MAX_TRACK_EN
module dist_calc_seq #(
  parameter int unsigned NUMBER_BITS = 32,
  parameter int unsigned FRAC_BITS   = 30,
  parameter int unsigned DIM         = 2,
  localparam int unsigned N          = DIM * DIM,
  localparam int unsigned IDX_W      = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int unsigned LOG_N      = (N > 1) ? $clog2(N) : 0,
  localparam int unsigned ACC_W      = NUMBER_BITS + 1 + LOG_N,
  localparam int unsigned OUT_W      = 2 * ACC_W + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          rd_en,
  output logic [IDX_W-1:0]              idx_row,
  output logic [IDX_W-1:0]              idx_col,
  input  logic signed [NUMBER_BITS-1:0] a_re,
  input  logic signed [NUMBER_BITS-1:0] a_im,
  input  logic signed [NUMBER_BITS-1:0] b_re,
  input  logic signed [NUMBER_BITS-1:0] b_im,
  output logic [OUT_W-1:0]              dist2,
`ifdef DIST_MAX_TRACK_EN
  output logic [OUT_W-1:0]              max_dist2,
  output logic                          new_max,
`endif
  output logic                          done
);

  localparam int unsigned PROD_W = 2 * NUMBER_BITS;
  localparam int unsigned SUM_W  = 2 * NUMBER_BITS + 1;
  localparam int unsigned SQ_W   = 2 * ACC_W;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    LAST   = 2'd2,
    SQUARE = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     rd_en_q, rd_en_d;
  logic                     vld_q, vld_d;
  logic                     done_q, done_d;
  logic [IDX_W-1:0]         row_q, row_d;
  logic [IDX_W-1:0]         col_q, col_d;
  logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;
  logic [OUT_W-1:0]         dist2_q, dist2_d;

  logic signed [PROD_W-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [SUM_W-1:0]  s_re, s_im;
  logic signed [ACC_W-1:0]  p_re, p_im;
  logic signed [SQ_W-1:0]   sq_re, sq_im;
  logic [OUT_W-1:0]         sq_sum;

  // conj(a)*b, each partial sum floored by FRAC_BITS then resized to the accumulator
  always_comb begin
    m_rr = PROD_W'(a_re) * PROD_W'(b_re);
    m_ii = PROD_W'(a_im) * PROD_W'(b_im);
    m_ri = PROD_W'(a_re) * PROD_W'(b_im);
    m_ir = PROD_W'(a_im) * PROD_W'(b_re);
    s_re = SUM_W'(m_rr) + SUM_W'(m_ii);
    s_im = SUM_W'(m_ri) - SUM_W'(m_ir);
    p_re = ACC_W'(s_re >>> FRAC_BITS);
    p_im = ACC_W'(s_im >>> FRAC_BITS);
  end

  // squared magnitude of the accumulator; squares are non-negative so zero-extend
  always_comb begin
    sq_re  = SQ_W'(acc_re_q) * SQ_W'(acc_re_q);
    sq_im  = SQ_W'(acc_im_q) * SQ_W'(acc_im_q);
    sq_sum = OUT_W'($unsigned(sq_re)) + OUT_W'($unsigned(sq_im));
  end

  // next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    rd_en_d  = rd_en_q;
    vld_d    = rd_en_q;   // read data returns one cycle after the request
    done_d   = 1'b0;
    row_d    = row_q;
    col_d    = col_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    dist2_d  = dist2_q;

    if (vld_q) begin
      acc_re_d = acc_re_q + p_re;
      acc_im_d = acc_im_q + p_im;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          busy_d   = 1'b1;
          rd_en_d  = 1'b1;
          row_d    = '0;
          col_d    = '0;
          acc_re_d = '0;
          acc_im_d = '0;
        end
      end
      FETCH: begin
        if (row_q == IDX_MAX && col_q == IDX_MAX) begin
          state_d = LAST;
          rd_en_d = 1'b0;
        end else if (col_q == IDX_MAX) begin
          col_d = '0;
          row_d = row_q + IDX_W'(1);
        end else begin
          col_d = col_q + IDX_W'(1);
        end
      end
      LAST: begin
        state_d = SQUARE;
      end
      SQUARE: begin
        dist2_d = sq_sum;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      dist2_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      rd_en_q  <= rd_en_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      row_q    <= row_d;
      col_q    <= col_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      dist2_q  <= dist2_d;
    end
  end

  assign busy    = busy_q;
  assign rd_en   = rd_en_q;
  assign idx_row = row_q;
  assign idx_col = col_q;
  assign dist2   = dist2_q;
  assign done    = done_q;

`ifdef DIST_MAX_TRACK_EN
  logic [OUT_W-1:0] max_q, max_d;
  logic             new_max_q, new_max_d;

  // track the largest result; only a strictly larger value raises new_max
  always_comb begin
    max_d     = max_q;
    new_max_d = 1'b0;
    if (state_q == SQUARE && sq_sum > max_q) begin
      max_d     = sq_sum;
      new_max_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q     <= '0;
      new_max_q <= 1'b0;
    end else begin
      max_q     <= max_d;
      new_max_q <= new_max_d;
    end
  end

  assign max_dist2 = max_q;
  assign new_max   = new_max_q;
`endif

endmodule
